// File: rtl/pieo_sublist_engine_pkg.sv
// Shared definitions for the PIEO sublist engine: default widths, empty-rank
// fill value, FSM state encoding and the send-time width helper.
// Optional feature macro used by this slice: PIEO_SUBLIST_DEQ_BY_ID_EN.
package pieo_pkg;

    localparam int unsigned DEF_DEPTH     = 8;
    localparam int unsigned DEF_RANK_W    = 4;
    localparam int unsigned DEF_TIME_W    = 6;
    localparam int unsigned DEF_ID_W      = 3;
    localparam int unsigned DEF_META_W    = 9;
    localparam int unsigned DEF_ELIG_MODE = 0;

    // All-ones rank marks an empty slot / infinity; sliced to RANK_W by users.
    localparam logic [31:0] EMPTY_RANK = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DEQ_EVAL,
        ST_DEQ_EXTRACT
    } pieo_state_e;

    // Bucket mode carries a bucket index, time mode a full timestamp.
    function automatic int unsigned st_width(input int unsigned elig_mode,
                                             input int unsigned time_w);
        return (elig_mode != 0) ? $clog2(time_w) : time_w;
    endfunction

endpackage

// File: rtl/pieo_sublist_engine_if.sv
// Enqueue / dequeue / response bundle of one PIEO sublist engine.
// PIEO_SUBLIST_DEQ_BY_ID_EN adds the dequeue-by-id request fields.
interface pieo_sublist_engine_if
    import pieo_pkg::*;
#(
    parameter int unsigned RANK_W = DEF_RANK_W,
    parameter int unsigned TIME_W = DEF_TIME_W,
    parameter int unsigned ID_W   = DEF_ID_W,
    parameter int unsigned META_W = DEF_META_W,
    parameter int unsigned ST_W   = DEF_TIME_W
) ();

    logic              enq_valid;
    logic              enq_ready;
    logic [ID_W-1:0]   enq_id;
    logic [RANK_W-1:0] enq_rank;
    logic [ST_W-1:0]   enq_send_time;
    logic [META_W-1:0] enq_meta;

    logic              deq_valid;
    logic              deq_ready;
    logic [TIME_W-1:0] deq_time;
`ifdef PIEO_SUBLIST_DEQ_BY_ID_EN
    logic              deq_by_id;
    logic [ID_W-1:0]   deq_id;
`endif

    logic              rsp_valid;
    logic              rsp_hit;
    logic [ID_W-1:0]   rsp_id;
    logic [RANK_W-1:0] rsp_rank;
    logic [ST_W-1:0]   rsp_send_time;
    logic [META_W-1:0] rsp_meta;

    modport master (
        output enq_valid, enq_id, enq_rank, enq_send_time, enq_meta,
        output deq_valid, deq_time,
`ifdef PIEO_SUBLIST_DEQ_BY_ID_EN
        output deq_by_id, deq_id,
`endif
        input  enq_ready, deq_ready,
        input  rsp_valid, rsp_hit, rsp_id, rsp_rank, rsp_send_time, rsp_meta
    );

    modport slave (
        input  enq_valid, enq_id, enq_rank, enq_send_time, enq_meta,
        input  deq_valid, deq_time,
`ifdef PIEO_SUBLIST_DEQ_BY_ID_EN
        input  deq_by_id, deq_id,
`endif
        output enq_ready, deq_ready,
        output rsp_valid, rsp_hit, rsp_id, rsp_rank, rsp_send_time, rsp_meta
    );

endinterface

// File: rtl/pieo_sublist_engine_first_set.sv
// Lowest-set-bit priority encoder: returns the index of the lowest set bit
// of vec and whether any bit was set.
module pieo_first_set #(
    parameter int unsigned W     = 8,
    parameter int unsigned IDX_W = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]     vec,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = W; i > 0; i--) begin
            if (vec[i-1]) begin
                idx   = IDX_W'(i - 1);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pieo_sublist_engine.sv
// PIEO sublist engine: DEPTH-entry register array sorted by rank (ascending,
// FIFO among equal ranks). Enqueue inserts in one cycle; dequeue evaluates
// eligibility, then extracts the lowest eligible entry two cycles after
// acceptance. Summary outputs feed the PIEO pointer array.
// Optional feature: PIEO_SUBLIST_DEQ_BY_ID_EN (dequeue by element id).
module pieo_sublist_engine
    import pieo_pkg::*;
#(
    parameter int unsigned DEPTH     = DEF_DEPTH,
    parameter int unsigned RANK_W    = DEF_RANK_W,
    parameter int unsigned TIME_W    = DEF_TIME_W,
    parameter int unsigned ID_W      = DEF_ID_W,
    parameter int unsigned META_W    = DEF_META_W,
    parameter int unsigned ELIG_MODE = DEF_ELIG_MODE,
    parameter int unsigned ST_W      = st_width(ELIG_MODE, TIME_W)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    pieo_sublist_engine_if.slave          bus,
    output logic [$clog2(DEPTH+1)-1:0]    num,
    output logic                          full,
    output logic [RANK_W-1:0]             smallest_rank,
    output logic [ST_W-1:0]               smallest_send_time
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned NUM_W = $clog2(DEPTH + 1);
    localparam logic [RANK_W-1:0] EMPTY_R = EMPTY_RANK[RANK_W-1:0];

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [RANK_W-1:0] rank;
        logic [ST_W-1:0]   send_time;
        logic [META_W-1:0] meta;
    } elem_t;

    localparam elem_t EMPTY_ELEM = '{id: '0, rank: EMPTY_R, send_time: '0, meta: '0};

    pieo_state_e       state_q, state_d;
    elem_t             ent_q [DEPTH];
    elem_t             ent_d [DEPTH];
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [DEPTH-1:0]  mask_q, mask_d;
    logic [TIME_W-1:0] deq_time_q, deq_time_d;
    logic [NUM_W-1:0]  num_q, num_d;
    logic              full_q, full_d;
    logic [RANK_W-1:0] srank_q, srank_d;
    logic [ST_W-1:0]   sst_q, sst_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_hit_q, rsp_hit_d;
    elem_t             rsp_elem_q, rsp_elem_d;
`ifdef PIEO_SUBLIST_DEQ_BY_ID_EN
    logic              by_id_q, by_id_d;
    logic [ID_W-1:0]   deq_id_q, deq_id_d;
    logic [DEPTH-1:0]  match_vec;
`endif

    elem_t             new_elem;
    logic [DEPTH-1:0]  ins_vec;
    logic [IDX_W-1:0]  ins_idx;
    logic              ins_found;
    logic [DEPTH-1:0]  elig_vec;
    logic [DEPTH-1:0]  sel_vec;
    logic [IDX_W-1:0]  ext_idx;
    logic              ext_found;
    logic              idle;
    logic              deq_fire;
    logic              enq_fire;

    assign new_elem = {bus.enq_id, bus.enq_rank, bus.enq_send_time, bus.enq_meta};
    assign idle     = (state_q == ST_IDLE);
    // Dequeue has priority; enqueue is held off while a dequeue is requested.
    assign deq_fire = idle & bus.deq_valid;
    assign enq_fire = idle & bus.enq_valid & ~bus.deq_valid & ~full_q & ins_found;

    assign bus.enq_ready     = idle & ~full_q & ~bus.deq_valid;
    assign bus.deq_ready     = idle;
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_hit       = rsp_hit_q;
    assign bus.rsp_id        = rsp_elem_q.id;
    assign bus.rsp_rank      = rsp_elem_q.rank;
    assign bus.rsp_send_time = rsp_elem_q.send_time;
    assign bus.rsp_meta      = rsp_elem_q.meta;

    assign num                = num_q;
    assign full               = full_q;
    assign smallest_rank      = srank_q;
    assign smallest_send_time = sst_q;

    // Insert slot: first invalid entry or first entry ranked strictly higher,
    // which keeps equal ranks in arrival order.
    for (genvar g = 0; g < DEPTH; g++) begin : g_ins
        assign ins_vec[g] = ~valid_q[g] | (ent_q[g].rank > bus.enq_rank);
    end

    pieo_first_set #(.W(DEPTH), .IDX_W(IDX_W)) u_ins_pos (
        .vec   (ins_vec),
        .idx   (ins_idx),
        .found (ins_found)
    );

    if (ELIG_MODE == 0) begin : g_time
        for (genvar g = 0; g < DEPTH; g++) begin : g_e
            assign elig_vec[g] = (ent_q[g].send_time <= deq_time_q);
        end
    end else begin : g_bucket
        // Bucket indices beyond TIME_W read zero-padded bitmap bits.
        localparam int unsigned BM_W = 1 << ST_W;
        logic [BM_W-1:0] bm;
        assign bm = BM_W'(deq_time_q);
        for (genvar g = 0; g < DEPTH; g++) begin : g_e
            assign elig_vec[g] = bm[ent_q[g].send_time];
        end
    end

`ifdef PIEO_SUBLIST_DEQ_BY_ID_EN
    for (genvar g = 0; g < DEPTH; g++) begin : g_match
        assign match_vec[g] = (ent_q[g].id == deq_id_q);
    end
    assign sel_vec = by_id_q ? match_vec : elig_vec;
`else
    assign sel_vec = elig_vec;
`endif

    pieo_first_set #(.W(DEPTH), .IDX_W(IDX_W)) u_ext_pos (
        .vec   (mask_q),
        .idx   (ext_idx),
        .found (ext_found)
    );

    // Next-state, array insert/extract and response generation.
    always_comb begin
        state_d     = state_q;
        ent_d       = ent_q;
        valid_d     = valid_q;
        mask_d      = mask_q;
        deq_time_d  = deq_time_q;
        num_d       = num_q;
        rsp_valid_d = 1'b0;
        rsp_hit_d   = 1'b0;
        rsp_elem_d  = '0;
`ifdef PIEO_SUBLIST_DEQ_BY_ID_EN
        by_id_d     = by_id_q;
        deq_id_d    = deq_id_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (deq_fire) begin
                    state_d    = ST_DEQ_EVAL;
                    deq_time_d = bus.deq_time;
`ifdef PIEO_SUBLIST_DEQ_BY_ID_EN
                    by_id_d    = bus.deq_by_id;
                    deq_id_d   = bus.deq_id;
`endif
                end else if (enq_fire) begin
                    if (ins_idx == '0) begin
                        ent_d[0]   = new_elem;
                        valid_d[0] = 1'b1;
                    end
                    for (int unsigned i = 1; i < DEPTH; i++) begin
                        if (IDX_W'(i) > ins_idx) begin
                            ent_d[i]   = ent_q[i-1];
                            valid_d[i] = valid_q[i-1];
                        end else if (IDX_W'(i) == ins_idx) begin
                            ent_d[i]   = new_elem;
                            valid_d[i] = 1'b1;
                        end
                    end
                    num_d = num_q + NUM_W'(1);
                end
            end
            ST_DEQ_EVAL: begin
                mask_d  = valid_q & sel_vec;
                state_d = ST_DEQ_EXTRACT;
            end
            ST_DEQ_EXTRACT: begin
                rsp_valid_d = 1'b1;
                if (ext_found) begin
                    rsp_hit_d  = 1'b1;
                    rsp_elem_d = ent_q[ext_idx];
                    for (int unsigned i = 0; i < DEPTH - 1; i++) begin
                        if (IDX_W'(i) >= ext_idx) begin
                            ent_d[i]   = ent_q[i+1];
                            valid_d[i] = valid_q[i+1];
                        end
                    end
                    ent_d[DEPTH-1]   = EMPTY_ELEM;
                    valid_d[DEPTH-1] = 1'b0;
                    num_d            = num_q - NUM_W'(1);
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Summary values derived from the next array so they move with it.
    always_comb begin
        full_d  = (num_d == NUM_W'(DEPTH));
        srank_d = ent_d[0].rank;
        sst_d   = '1;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (valid_d[i] && (ent_d[i].send_time < sst_d)) begin
                sst_d = ent_d[i].send_time;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Array, mask, summary and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ent_q[i] <= EMPTY_ELEM;
            end
            valid_q     <= '0;
            mask_q      <= '0;
            deq_time_q  <= '0;
            num_q       <= '0;
            full_q      <= 1'b0;
            srank_q     <= '1;
            sst_q       <= '1;
            rsp_valid_q <= 1'b0;
            rsp_hit_q   <= 1'b0;
            rsp_elem_q  <= '0;
`ifdef PIEO_SUBLIST_DEQ_BY_ID_EN
            by_id_q     <= 1'b0;
            deq_id_q    <= '0;
`endif
        end else begin
            ent_q       <= ent_d;
            valid_q     <= valid_d;
            mask_q      <= mask_d;
            deq_time_q  <= deq_time_d;
            num_q       <= num_d;
            full_q      <= full_d;
            srank_q     <= srank_d;
            sst_q       <= sst_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_hit_q   <= rsp_hit_d;
            rsp_elem_q  <= rsp_elem_d;
`ifdef PIEO_SUBLIST_DEQ_BY_ID_EN
            by_id_q     <= by_id_d;
            deq_id_q    <= deq_id_d;
`endif
        end
    end

endmodule

// File: tb/tb_pieo_sublist_engine.sv
// Scoreboard bench for pieo_sublist_engine: a time-compare instance and a
// bucket-bitmap instance. Dequeue drivers push expected responses; per-instance
// monitors pop and compare whenever rsp_valid is seen, including latency.
module tb_pieo_sublist_engine;
    import pieo_pkg::*;

    localparam int unsigned DEPTH  = 8;
    localparam int unsigned RANK_W = 4;
    localparam int unsigned TIME_W = 6;
    localparam int unsigned ID_W   = 3;
    localparam int unsigned META_W = 9;
    localparam int unsigned ST0    = 6;
    localparam int unsigned ST1    = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    typedef struct {
        int unsigned hit;
        int unsigned id;
        int unsigned rank;
        int unsigned st;
        int unsigned meta;
        int unsigned acc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    pieo_sublist_engine_if #(.RANK_W(RANK_W), .TIME_W(TIME_W), .ID_W(ID_W),
                             .META_W(META_W), .ST_W(ST0)) b0 ();
    pieo_sublist_engine_if #(.RANK_W(RANK_W), .TIME_W(TIME_W), .ID_W(ID_W),
                             .META_W(META_W), .ST_W(ST1)) b1 ();

    logic [3:0]        num0, num1;
    logic              full0, full1;
    logic [RANK_W-1:0] srank0, srank1;
    logic [ST0-1:0]    sst0;
    logic [ST1-1:0]    sst1;

    pieo_sublist_engine #(.DEPTH(DEPTH), .RANK_W(RANK_W), .TIME_W(TIME_W), .ID_W(ID_W),
                          .META_W(META_W), .ELIG_MODE(0), .ST_W(ST0)) u_dut0 (
        .clk                (clk),
        .rst_n              (rst_n),
        .bus                (b0.slave),
        .num                (num0),
        .full               (full0),
        .smallest_rank      (srank0),
        .smallest_send_time (sst0)
    );

    pieo_sublist_engine #(.DEPTH(DEPTH), .RANK_W(RANK_W), .TIME_W(TIME_W), .ID_W(ID_W),
                          .META_W(META_W), .ELIG_MODE(1), .ST_W(ST1)) u_dut1 (
        .clk                (clk),
        .rst_n              (rst_n),
        .bus                (b1.slave),
        .num                (num1),
        .full               (full1),
        .smallest_rank      (srank1),
        .smallest_send_time (sst1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic cmp_rsp(input string tag, input exp_t e, input logic hit, input logic [31:0] id,
                           input logic [31:0] rank, input logic [31:0] st, input logic [31:0] meta);
        chk({tag, "_hit"},     {31'd0, hit}, e.hit);
        chk({tag, "_id"},      id,   e.id);
        chk({tag, "_rank"},    rank, e.rank);
        chk({tag, "_st"},      st,   e.st);
        chk({tag, "_meta"},    meta, e.meta);
        chk({tag, "_latency"}, cyc - e.acc, 2);
    endtask

    // Monitors: every response pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && b0.rsp_valid === 1'b1) begin
            exp_t e;
            if (q0.size() == 0) begin
                chk("rsp0_unexpected", 1, 0);
            end else begin
                e = q0.pop_front();
                cmp_rsp("rsp0", e, b0.rsp_hit, 32'(b0.rsp_id), 32'(b0.rsp_rank),
                        32'(b0.rsp_send_time), 32'(b0.rsp_meta));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && b1.rsp_valid === 1'b1) begin
            exp_t e;
            if (q1.size() == 0) begin
                chk("rsp1_unexpected", 1, 0);
            end else begin
                e = q1.pop_front();
                cmp_rsp("rsp1", e, b1.rsp_hit, 32'(b1.rsp_id), 32'(b1.rsp_rank),
                        32'(b1.rsp_send_time), 32'(b1.rsp_meta));
            end
        end
    end

    task automatic enq(input int unsigned u, input int unsigned id, input int unsigned rank,
                       input int unsigned st, input int unsigned meta);
        @(negedge clk);
        if (u == 0) begin
            b0.enq_valid = 1'b1; b0.enq_id = ID_W'(id); b0.enq_rank = RANK_W'(rank);
            b0.enq_send_time = ST0'(st); b0.enq_meta = META_W'(meta);
        end else begin
            b1.enq_valid = 1'b1; b1.enq_id = ID_W'(id); b1.enq_rank = RANK_W'(rank);
            b1.enq_send_time = ST1'(st); b1.enq_meta = META_W'(meta);
        end
        @(posedge clk); #1;
        b0.enq_valid = 1'b0;
        b1.enq_valid = 1'b0;
    endtask

    // Issues one dequeue, records the expected response at acceptance, then
    // waits until the engine is back in IDLE.
    task automatic deq(input int unsigned u, input int unsigned dt, input int unsigned hit,
                       input int unsigned id, input int unsigned rank,
                       input int unsigned st, input int unsigned meta);
        exp_t e;
        int unsigned w;
        @(negedge clk);
        if (u == 0) begin b0.deq_valid = 1'b1; b0.deq_time = TIME_W'(dt); end
        else        begin b1.deq_valid = 1'b1; b1.deq_time = TIME_W'(dt); end
        #1;
        w = 0;
        while (((u == 0) ? b0.deq_ready : b1.deq_ready) !== 1'b1 && w < 20) begin
            @(negedge clk); #1; w++;
        end
        if (w == 20) begin
            chk("deq_ready_timeout", 0, 1);
            b0.deq_valid = 1'b0;
            b1.deq_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        e.hit = hit; e.id = id; e.rank = rank; e.st = st; e.meta = meta; e.acc = cyc;
        if (u == 0) q0.push_back(e); else q1.push_back(e);
        b0.deq_valid = 1'b0;
        b1.deq_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int unsigned w;
        b0.enq_valid = 1'b0; b0.enq_id = '0; b0.enq_rank = '0; b0.enq_send_time = '0; b0.enq_meta = '0;
        b0.deq_valid = 1'b0; b0.deq_time = '0;
        b1.enq_valid = 1'b0; b1.enq_id = '0; b1.enq_rank = '0; b1.enq_send_time = '0; b1.enq_meta = '0;
        b1.deq_valid = 1'b0; b1.deq_time = '0;
`ifdef PIEO_SUBLIST_DEQ_BY_ID_EN
        b0.deq_by_id = 1'b0; b0.deq_id = '0;
        b1.deq_by_id = 1'b0; b1.deq_id = '0;
`endif
        #12;
        // Reset values
        chk("rst_num", 32'(num0), 0);
        chk("rst_full", 32'(full0), 0);
        chk("rst_srank", 32'(srank0), 15);
        chk("rst_sst", 32'(sst0), 63);
        chk("rst_sst1", 32'(sst1), 7);
        chk("rst_enq_ready", 32'(b0.enq_ready), 1);
        chk("rst_deq_ready", 32'(b0.deq_ready), 1);
        chk("rst_rsp_valid", 32'(b0.rsp_valid), 0);
        chk("rst_rsp_rank", 32'(b0.rsp_rank), 0);
        @(negedge clk); rst_n = 1'b1;

        // Rank order with FIFO tie-break: ranks 5,2,7,2 -> ids 1,3,0,2
        enq(0, 0, 5, 10, 100);
        enq(0, 1, 2, 11, 101);
        enq(0, 2, 7, 12, 102);
        enq(0, 3, 2, 13, 103);
        chk("order_num", 32'(num0), 4);
        chk("order_srank", 32'(srank0), 2);
        chk("order_sst", 32'(sst0), 10);
        deq(0, 63, 1, 1, 2, 11, 101);
        deq(0, 63, 1, 3, 2, 13, 103);
        deq(0, 63, 1, 0, 5, 10, 100);
        deq(0, 63, 1, 2, 7, 12, 102);
        chk("order_num_empty", 32'(num0), 0);
        chk("order_srank_empty", 32'(srank0), 15);

        // Time eligibility skips the lower-rank but later entry
        enq(0, 4, 1, 9, 7);
        enq(0, 5, 3, 2, 8);
        chk("elig_num2", 32'(num0), 2);
        chk("elig_sst", 32'(sst0), 2);
        deq(0, 4, 1, 5, 3, 2, 8);
        chk("elig_num1", 32'(num0), 1);
        chk("elig_srank", 32'(srank0), 1);
        chk("elig_sst_after", 32'(sst0), 9);
        deq(0, 4, 0, 0, 0, 0, 0);
        chk("elig_miss_num", 32'(num0), 1);
        deq(0, 9, 1, 4, 1, 9, 7);
        chk("elig_num0", 32'(num0), 0);

        // Bucket bitmap mode
        enq(1, 0, 2, 5, 20);
        enq(1, 1, 6, 1, 21);
        chk("bkt_num", 32'(num1), 2);
        chk("bkt_sst", 32'(sst1), 1);
        deq(1, 2, 1, 1, 6, 1, 21);
        chk("bkt_num1", 32'(num1), 1);
        chk("bkt_srank", 32'(srank1), 2);
        chk("bkt_sst_after", 32'(sst1), 5);
        deq(1, 2, 0, 0, 0, 0, 0);
        deq(1, 32, 1, 0, 2, 5, 20);
        chk("bkt_num0", 32'(num1), 0);

        // Fill to DEPTH; ninth enqueue is refused
        for (int unsigned i = 0; i < DEPTH; i++) enq(0, i, 7 - i, i, 40 + i);
        chk("full_num", 32'(num0), 8);
        chk("full_flag", 32'(full0), 1);
        chk("full_enq_ready", 32'(b0.enq_ready), 0);
        chk("full_srank", 32'(srank0), 0);
        chk("full_sst", 32'(sst0), 0);
        enq(0, 5, 0, 30, 300);
        chk("full_refused_num", 32'(num0), 8);
        for (int unsigned i = 0; i < DEPTH; i++) deq(0, 63, 1, 7 - i, i, 7 - i, 47 - i);
        chk("drain_num", 32'(num0), 0);
        chk("drain_full", 32'(full0), 0);
        deq(0, 63, 0, 0, 0, 0, 0);

        // Simultaneous enqueue and dequeue: dequeue wins
        @(negedge clk);
        b0.enq_valid = 1'b1; b0.enq_id = 3'd2; b0.enq_rank = 4'd4; b0.enq_send_time = 6'd1; b0.enq_meta = 9'd5;
        b0.deq_valid = 1'b1; b0.deq_time = 6'd63;
        #1;
        chk("sim_enq_ready", 32'(b0.enq_ready), 0);
        chk("sim_deq_ready", 32'(b0.deq_ready), 1);
        @(posedge clk); #1;
        begin
            exp_t e;
            e.hit = 0; e.id = 0; e.rank = 0; e.st = 0; e.meta = 0; e.acc = cyc;
            q0.push_back(e);
        end
        b0.deq_valid = 1'b0;
        chk("sim_enq_ready_eval", 32'(b0.enq_ready), 0);
        repeat (2) @(posedge clk);
        #1;
        chk("sim_num_at_idle", 32'(num0), 0);
        chk("sim_enq_ready_idle", 32'(b0.enq_ready), 1);
        @(posedge clk); #1;
        b0.enq_valid = 1'b0;
        chk("sim_num_landed", 32'(num0), 1);
        chk("sim_srank", 32'(srank0), 4);
        deq(0, 63, 1, 2, 4, 1, 5);

`ifdef PIEO_SUBLIST_DEQ_BY_ID_EN
        // Dequeue by id ignores eligibility and removes only the matching id
        enq(0, 1, 1, 50, 11);
        enq(0, 3, 2, 50, 13);
        enq(0, 5, 3, 50, 15);
        b0.deq_by_id = 1'b1; b0.deq_id = 3'd3;
        deq(0, 0, 1, 3, 2, 50, 13);
        chk("byid_num", 32'(num0), 2);
        chk("byid_srank", 32'(srank0), 1);
        deq(0, 0, 0, 0, 0, 0, 0);
        b0.deq_by_id = 1'b0;
        deq(0, 63, 1, 1, 1, 50, 11);
        deq(0, 63, 1, 5, 3, 50, 15);
`endif

        // Reset while in DEQ_EVAL: no response, array emptied
        enq(0, 6, 3, 4, 9);
        @(negedge clk);
        b0.deq_valid = 1'b1; b0.deq_time = 6'd63;
        @(posedge clk); #1;
        b0.deq_valid = 1'b0;
        rst_n = 1'b0;
        #2;
        chk("midrst_num", 32'(num0), 0);
        chk("midrst_srank", 32'(srank0), 15);
        @(negedge clk); rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("midrst_num_after", 32'(num0), 0);
        chk("midrst_deq_ready", 32'(b0.deq_ready), 1);

        w = 0;
        while ((q0.size() != 0 || q1.size() != 0) && w < 20) begin
            @(posedge clk); w++;
        end
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
